proj_input_merger: RTL and testbench
====================================

Name: proj_input_merger

Overview:
- Parametrised input stage for the next-generation projection router.
- Reads up to NCH paged projection memories (TPROJ-style) for one BX and merges them into a single ready/valid stream, tagged with the source channel.
- Generalises the fixed 8-input, 2-page read side: channel count, data width, depth, page count and read latency are parameters.
- Adds downstream backpressure, a per-event cycle budget (truncation) and explicit done/bx_out signalling.

Parameters:
- NCH, 8, number of input memories.
- DATA_W, 60, projection word width.
- ADDR_W, 7, entry address bits per page (page depth 2^ADDR_W).
- NPAGE, 2, BX pages per memory (power of 2); PAGE_W = clog2(NPAGE).
- NENT_W, 8, width of each nentries word.
- BX_W, 3, BX number width.
- RD_LAT, 2, memory read latency in cycles (address to dout).
- MAX_CYC, 108, read-issue budget per event in cycles.

Ports:
- clk, in, 1, clock.
- reset, in, 1, reset (see Behaviour for polarity and timing).
- start, in, 1, start-of-event pulse.
- bx_in, in, BX_W, BX of the event.
- in_enb, out, NCH, read enable per memory.
- in_readaddr, out, NCH*(PAGE_W+ADDR_W), flattened read addresses {page,entry}.
- in_dout, in, NCH*DATA_W, flattened read data.
- in_nentries, in, NCH*NPAGE*NENT_W, entry counts, flattened channel-major.
- out_valid, out, 1, merged word valid.
- out_ready, in, 1, downstream accept.
- out_data, out, DATA_W, projection word.
- out_chan, out, clog2(NCH), source channel.
- bx_out, out, BX_W, BX of the last completed event.
- done, out, 1, one-cycle end-of-event pulse.
- truncated, out, 1, event hit MAX_CYC with entries unread.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on port reset.
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; counters cleared.
- Reset asserted mid-event aborts the event: no done pulse, in-flight data discarded.
- FSM states:
  - IDLE: start=1 -> RUN. Latch bx_in and page = bx_in[PAGE_W-1:0]. Snapshot nentries[ch][page] for each channel, clamped to 2^ADDR_W. Clear rdptr[ch], cycle counter, credits and truncated.
  - RUN: read issue as below. Move to DRAIN when all channels are exhausted or the cycle counter reaches MAX_CYC. On the budget exit, set truncated if any channel still has remaining entries.
  - DRAIN: wait for in-flight reads = 0 and FIFO empty -> DONE.
  - DONE: done=1 and bx_out <= latched bx for exactly one cycle -> IDLE.
- start is ignored outside IDLE.
- start in the cycle DONE is active is also ignored; the earliest accepted start is the first IDLE cycle.
- truncated holds until the next accepted start.
- Read issue in RUN: at most one read per cycle.
  - Channel = lowest index with rdptr < count (fixed priority).
  - Issue only if free FIFO slots minus in-flight reads > 0 (credit rule; never overflows).
  - Drive in_enb[ch]=1 and in_readaddr[ch]={page,rdptr}, then rdptr++.
  - Non-selected channels: enb=0, address held.
- Channel tag and valid travel through an RD_LAT-deep shift register aligned with in_dout.
- On arrival, the selected DATA_W slice is pushed into a skid FIFO of depth RD_LAT+2.
- Output: out_valid = FIFO non-empty; out_data/out_chan from the FIFO head; pop on out_valid & out_ready.
- Push and pop in the same cycle: occupancy unchanged.
- Latency from issue to earliest out_valid: RD_LAT+1 cycles.
- Cycle counter runs every RUN cycle, including stalled ones.
- Zero entries on all channels: RUN lasts 1 cycle, then DRAIN, then done; 3 cycles from start to done.
- nentries above 2^ADDR_W is clamped; addresses never wrap into the next page.

Decomposition:
- Shared package proj_merge_pkg:
  - clog2 function.
  - FSM state enum.
  - Helper functions for flattened-slice indexing of channel data, address and nentries.
- One natural sub-module: proj_skid_fifo, a parametrised synchronous FIFO with DEPTH and WIDTH parameters, count output and same-cycle push/pop.
- The read-latency shift register stays inline.

Test Plan:
- NCH=8, page 0 counts {3,0,2,0,0,0,0,1}, bx_in=4, out_ready=1 -> 6 words in order ch0 x3, ch2 x2, ch7 x1, addresses 0..n-1; done pulses once; bx_out=4; truncated=0.
- bx_in=5 (page 1), page-1 counts differ from page 0 -> addresses carry page bit 1; only page-1 counts are honoured.
- ch0 count 200 with MAX_CYC=108, out_ready=1 -> exactly 108 words; truncated=1; done after drain.
- out_ready=0 for 20 cycles mid-event -> in-flight reads never exceed free slots; no word lost or duplicated; stream resumes in order.
- All counts 0 -> done 3 cycles after start; out_valid never asserted.
- reset asserted mid-RUN, then a new start -> no stale output, no done for the aborted event; the second event completes correctly.

Source files
------------

// File: rtl/proj_merge_pkg.sv
// Shared types and index helpers for the projection input merger.
// All flattened buses are channel-major; nentries is additionally page-minor.
package proj_merge_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (longint unsigned v = 1; v < longint'(n); v = v << 1) r++;
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  function automatic int unsigned data_lsb(input int unsigned ch, input int unsigned data_w);
    return ch * data_w;
  endfunction

  function automatic int unsigned addr_lsb(input int unsigned ch, input int unsigned ra_w);
    return ch * ra_w;
  endfunction

  function automatic int unsigned nent_lsb(input int unsigned ch, input int unsigned page,
                                           input int unsigned npage,
                                           input int unsigned nent_w);
    return (ch * npage + page) * nent_w;
  endfunction

endpackage

// File: rtl/proj_skid_fifo.sv
// Small synchronous FIFO with occupancy count; push and pop may coincide.
// Storage is cleared on reset so the head reads zero while empty after reset.
module proj_skid_fifo
  import proj_merge_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_wdata,
  input  logic                           i_pop,
  output logic [WIDTH-1:0]               o_rdata,
  output logic                           o_empty,
  output logic [idx_w(DEPTH+1)-1:0]      o_count
);

  localparam int unsigned PTR_W = idx_w(DEPTH);
  localparam int unsigned CNT_W = idx_w(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr, r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             w_do_push, w_do_pop;

  assign w_do_pop  = i_pop && (r_cnt != '0);
  assign w_do_push = i_push && ((r_cnt != CNT_W'(DEPTH)) || w_do_pop);
  assign o_rdata   = r_mem[r_rd];
  assign o_empty   = (r_cnt == '0);
  assign o_count   = r_cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_wdata;
        r_wr        <= (r_wr == PTR_W'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      end
      if (w_do_pop) r_rd <= (r_rd == PTR_W'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_do_pop && !w_do_push) r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/proj_input_merger.sv
// Reads one BX page from NCH projection memories and merges them into a single
// channel-tagged ready/valid stream, with credit-based flow control and a cycle budget.
module proj_input_merger
  import proj_merge_pkg::*;
#(
  parameter int unsigned NCH     = 8,
  parameter int unsigned DATA_W  = 60,
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned NPAGE   = 2,
  parameter int unsigned NENT_W  = 8,
  parameter int unsigned BX_W    = 3,
  parameter int unsigned RD_LAT  = 2,
  parameter int unsigned MAX_CYC = 108
) (
  input  logic                                i_clk,
  input  logic                                i_reset_n,
  input  logic                                i_start,
  input  logic [BX_W-1:0]                     i_bx_in,
  output logic [NCH-1:0]                      o_in_enb,
  output logic [NCH*(clog2(NPAGE)+ADDR_W)-1:0] o_in_readaddr,
  input  logic [NCH*DATA_W-1:0]               i_in_dout,
  input  logic [NCH*NPAGE*NENT_W-1:0]         i_in_nentries,
  output logic                                o_out_valid,
  input  logic                                i_out_ready,
  output logic [DATA_W-1:0]                   o_out_data,
  output logic [idx_w(NCH)-1:0]               o_out_chan,
  output logic [BX_W-1:0]                     o_bx_out,
  output logic                                o_done,
  output logic                                o_truncated
);

  localparam int unsigned PAGE_W   = clog2(NPAGE);
  localparam int unsigned CH_W     = idx_w(NCH);
  localparam int unsigned RA_W     = PAGE_W + ADDR_W;
  localparam int unsigned CNT_W    = ADDR_W + 1;
  localparam int unsigned CYC_W    = idx_w(MAX_CYC + 1);
  localparam int unsigned DEPTH    = RD_LAT + 2;
  localparam int unsigned FCNT_W   = idx_w(DEPTH + 1);
  localparam int unsigned PAGE_MAX = 2 ** ADDR_W;

  state_e            r_state, w_state_d;
  logic [BX_W-1:0]   r_bx, r_bx_out;
  logic [PAGE_W-1:0] r_page, w_snap_page;
  logic [CNT_W-1:0]  r_cnt [NCH];
  logic [CNT_W-1:0]  r_rdptr [NCH];
  logic [CNT_W-1:0]  w_snap_cnt [NCH];
  logic [RA_W-1:0]   r_addr_hold [NCH];
  logic [CYC_W-1:0]  r_cyc;
  logic              r_trunc;
  logic [RD_LAT-1:0] r_sr_vld;
  logic [CH_W-1:0]   r_sr_ch [RD_LAT];

  logic              w_any_left, w_left_after, w_issue, w_credit_ok, w_budget_end;
  logic [CH_W-1:0]   w_sel, w_arr_ch;
  logic [RA_W-1:0]   w_issue_addr;
  int                w_inflight;
  logic              w_push, w_pop, w_fifo_empty;
  logic [FCNT_W-1:0] w_fifo_cnt;
  logic [DATA_W+CH_W-1:0] w_fifo_rdata;

  assign w_snap_page = i_bx_in[PAGE_W-1:0];

  // Entry counts for the incoming event, clamped so reads never cross into the next page.
  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      logic [NENT_W-1:0] n;
      n = i_in_nentries[nent_lsb(ch, 32'(w_snap_page), NPAGE, NENT_W) +: NENT_W];
      w_snap_cnt[ch] = (32'(n) > PAGE_MAX) ? CNT_W'(PAGE_MAX) : CNT_W'(n);
    end
  end

  always_comb begin
    w_any_left = 1'b0;
    w_sel      = '0;
    for (int ch = NCH - 1; ch >= 0; ch--) begin
      if (r_rdptr[ch] < r_cnt[ch]) begin
        w_any_left = 1'b1;
        w_sel      = CH_W'(ch);
      end
    end
  end

  // Credits: a read may only go out if its word is guaranteed a FIFO slot on arrival.
  assign w_inflight   = $countones(r_sr_vld);
  assign w_credit_ok  = (int'(DEPTH) - int'(w_fifo_cnt) - w_inflight) > 0;
  assign w_issue      = (r_state == StRun) && w_any_left && w_credit_ok;
  assign w_budget_end = (r_cyc == CYC_W'(MAX_CYC - 1));
  assign w_issue_addr = {r_page, r_rdptr[w_sel][ADDR_W-1:0]};

  always_comb begin
    w_left_after = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      if ((r_rdptr[ch] < r_cnt[ch]) &&
          !(w_issue && (w_sel == CH_W'(ch)) && (r_rdptr[ch] + 1'b1 == r_cnt[ch]))) begin
        w_left_after = 1'b1;
      end
    end
  end

  always_comb begin
    o_in_enb      = '0;
    o_in_readaddr = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      o_in_enb[ch] = w_issue && (w_sel == CH_W'(ch));
      o_in_readaddr[addr_lsb(ch, RA_W) +: RA_W] = o_in_enb[ch] ? w_issue_addr : r_addr_hold[ch];
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (i_start) w_state_d = StRun;
      StRun:   if (!w_any_left || w_budget_end) w_state_d = StDrain;
      StDrain: if ((w_inflight == 0) && w_fifo_empty) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= StIdle;
      r_bx     <= '0;
      r_bx_out <= '0;
      r_page   <= '0;
      r_cyc    <= '0;
      r_trunc  <= 1'b0;
      r_sr_vld <= '0;
      for (int ch = 0; ch < NCH; ch++) begin
        r_cnt[ch]       <= '0;
        r_rdptr[ch]     <= '0;
        r_addr_hold[ch] <= '0;
      end
      for (int i = 0; i < RD_LAT; i++) r_sr_ch[i] <= '0;
    end else begin
      r_state     <= w_state_d;
      r_sr_vld[0] <= w_issue;
      r_sr_ch[0]  <= w_sel;
      for (int i = 1; i < RD_LAT; i++) begin
        r_sr_vld[i] <= r_sr_vld[i-1];
        r_sr_ch[i]  <= r_sr_ch[i-1];
      end
      if ((r_state == StIdle) && i_start) begin
        r_bx    <= i_bx_in;
        r_page  <= w_snap_page;
        r_cyc   <= '0;
        r_trunc <= 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
          r_cnt[ch]   <= w_snap_cnt[ch];
          r_rdptr[ch] <= '0;
        end
      end
      if (r_state == StRun) begin
        r_cyc <= r_cyc + 1'b1;
        if (w_budget_end && w_left_after) r_trunc <= 1'b1;
      end
      if (w_issue) begin
        r_rdptr[w_sel]     <= r_rdptr[w_sel] + 1'b1;
        r_addr_hold[w_sel] <= w_issue_addr;
      end
      if ((r_state == StDrain) && (w_state_d == StDone)) r_bx_out <= r_bx;
    end
  end

  assign w_push   = r_sr_vld[RD_LAT-1];
  assign w_arr_ch = r_sr_ch[RD_LAT-1];
  assign w_pop    = o_out_valid && i_out_ready;

  proj_skid_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + CH_W)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (w_push),
    .i_wdata   ({w_arr_ch, i_in_dout[data_lsb(32'(w_arr_ch), DATA_W) +: DATA_W]}),
    .i_pop     (w_pop),
    .o_rdata   (w_fifo_rdata),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_cnt)
  );

  assign o_out_valid = !w_fifo_empty;
  assign o_out_data  = w_fifo_rdata[DATA_W-1:0];
  assign o_out_chan  = w_fifo_rdata[DATA_W+CH_W-1:DATA_W];
  assign o_done      = (r_state == StDone);
  assign o_bx_out    = r_bx_out;
  assign o_truncated = r_trunc;

endmodule

// File: tb/tb_proj_input_merger.sv
// Directed bench for proj_input_merger: a 2-cycle-latency memory model per channel
// returns a word encoding {channel, read address}, and the merged stream is checked in order.
module tb_proj_input_merger;

  localparam int NCH = 8;
  localparam int DW  = 60;
  localparam int RAW = 8;

  typedef struct packed {
    logic [2:0]    ch;
    logic [DW-1:0] d;
  } wd_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [2:0]        bx_in = '0;
  logic [NCH-1:0]    in_enb;
  logic [NCH*RAW-1:0] in_readaddr;
  logic [NCH*DW-1:0] in_dout;
  logic [NCH*2*8-1:0] in_nentries;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DW-1:0]     out_data;
  logic [2:0]        out_chan;
  logic [2:0]        bx_out;
  logic              done;
  logic              truncated;

  logic [7:0]    nent [NCH][2];
  logic [DW-1:0] s1 [NCH];
  logic [DW-1:0] s2 [NCH];

  int  n_chk = 0, n_fail = 0;
  int  cyc = 0, start_cyc = 0;
  int  done_cnt = 0, last_done_cyc = 0, vld_cnt = 0, multi_enb = 0, outst = 0, max_out = 0;
  wd_t got[$];
  wd_t exp_q[$];
  int  enb_q[$];
  int  vq[$];

  proj_input_merger dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_start       (start),
    .i_bx_in       (bx_in),
    .o_in_enb      (in_enb),
    .o_in_readaddr (in_readaddr),
    .i_in_dout     (in_dout),
    .i_in_nentries (in_nentries),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_out_data    (out_data),
    .o_out_chan    (out_chan),
    .o_bx_out      (bx_out),
    .o_done        (done),
    .o_truncated   (truncated)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mkword(input int ch, input int ra);
    return 60'hA50_0000_0000_0000 | (60'(ch) << 16) | 60'(ra);
  endfunction

  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      in_dout[ch*DW +: DW] = s2[ch];
      for (int p = 0; p < 2; p++) in_nentries[(ch*2+p)*8 +: 8] = nent[ch][p];
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int ch = 0; ch < NCH; ch++) begin
      if (in_enb[ch]) s1[ch] <= mkword(ch, int'(in_readaddr[ch*RAW +: RAW]));
      s2[ch] <= s1[ch];
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      outst <= 0;
    end else begin
      if (out_valid && out_ready) got.push_back({out_chan, out_data});
      if (out_valid) begin
        vld_cnt <= vld_cnt + 1;
        vq.push_back(cyc);
      end
      if (in_enb != '0) enb_q.push_back(cyc);
      if ($countones(in_enb) > 1) multi_enb <= multi_enb + 1;
      if (done) begin
        done_cnt      <= done_cnt + 1;
        last_done_cyc <= cyc;
      end
      outst <= outst + $countones(in_enb) - ((out_valid && out_ready) ? 1 : 0);
      if (outst > max_out) max_out <= outst;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_counts();
    for (int ch = 0; ch < NCH; ch++) begin
      nent[ch][0] = 8'd0;
      nent[ch][1] = 8'd0;
    end
  endtask

  task automatic build_exp(input int page, input int budget);
    int issued;
    issued = 0;
    exp_q.delete();
    for (int ch = 0; ch < NCH; ch++) begin
      int n;
      n = int'(nent[ch][page]);
      if (n > 128) n = 128;
      for (int a = 0; a < n; a++) begin
        if (issued < budget) exp_q.push_back({3'(ch), mkword(ch, page * 128 + a)});
        issued++;
      end
    end
  endtask

  task automatic start_event(input logic [2:0] bx);
    @(posedge clk); #1;
    start     = 1'b1;
    bx_in     = bx;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, input string tag);
    int k;
    k = 0;
    while (done_cnt == base && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check({tag, "_done"}, 64'(done_cnt - base), 64'd1);
    repeat (4) @(negedge clk);
    #1;
    check({tag, "_one_done"}, 64'(done_cnt - base), 64'd1);
  endtask

  task automatic cmp_words(input int base, input string tag);
    check({tag, "_nwords"}, 64'(got.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base + i < got.size(); i++) begin
      check($sformatf("%s_ch%0d", tag, i), 64'(got[base+i].ch), 64'(exp_q[i].ch));
      check($sformatf("%s_data%0d", tag, i), 64'(got[base+i].d), 64'(exp_q[i].d));
    end
  endtask

  initial begin
    int gb, db, vb, eb, vqb;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gb, db, vb, eb, vqb;
    clear_counts();
    for (int ch = 0; ch < NCH; ch++) begin
      s1[ch] = '0;
      s2[ch] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_trunc", 64'(truncated), 64'd0);
    check("rst_bx_out", 64'(bx_out), 64'd0);
    check("rst_enb", 64'(in_enb), 64'd0);
    check("rst_addr", 64'(in_readaddr), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;

    // E1: page 0, mixed counts, free-flowing output.
    clear_counts();
    nent[0][0] = 8'd3; nent[2][0] = 8'd2; nent[7][0] = 8'd1;
    for (int ch = 0; ch < NCH; ch++) nent[ch][1] = 8'd1;
    build_exp(0, 1000);
    gb = got.size(); db = done_cnt; eb = enb_q.size(); vqb = vq.size();
    start_event(3'd4);
    wait_done(db, 100, "e1");
    cmp_words(gb, "e1");
    check("e1_bx_out", 64'(bx_out), 64'd4);
    check("e1_trunc", 64'(truncated), 64'd0);
    check("e1_first_issue", 64'(enb_q[eb] - start_cyc), 64'd1);
    check("e1_latency", 64'(vq[vqb] - enb_q[eb]), 64'd3);

    // E2: page 1 selected by bx=5; page 0 counts must be ignored.
    clear_counts();
    nent[0][0] = 8'd5; nent[3][0] = 8'd2;
    nent[1][1] = 8'd4; nent[4][1] = 8'd1; nent[6][1] = 8'd2;
    build_exp(1, 1000);
    gb = got.size(); db = done_cnt;
    start_event(3'd5);
    wait_done(db, 100, "e2");
    cmp_words(gb, "e2");
    check("e2_bx_out", 64'(bx_out), 64'd5);

    // E3: ch0 has 200 entries, clamped to 128 and cut at the 108-cycle budget.
    clear_counts();
    nent[0][0] = 8'd200;
    build_exp(0, 108);
    gb = got.size(); db = done_cnt;
    start_event(3'd0);
    wait_done(db, 400, "e3");
    cmp_words(gb, "e3");
    check("e3_trunc", 64'(truncated), 64'd1);
    check("e3_bx_out", 64'(bx_out), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    check("e3_trunc_hold", 64'(truncated), 64'd1);

    // E4: 20-cycle backpressure mid-event.
    clear_counts();
    nent[0][0] = 8'd4; nent[1][0] = 8'd3; nent[3][0] = 8'd5;
    build_exp(0, 1000);
    gb = got.size(); db = done_cnt;
    start_event(3'd2);
    check("e4_trunc_clear", 64'(truncated), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done(db, 200, "e4");
    cmp_words(gb, "e4");
    check("e4_max_outstanding", 64'(max_out), 64'd4);
    check("e4_single_enb", 64'(multi_enb), 64'd0);

    // E5: nothing to read; done three cycles after start.
    clear_counts();
    db = done_cnt; vb = vld_cnt;
    start_event(3'd3);
    wait_done(db, 20, "e5");
    check("e5_start_to_done", 64'(last_done_cyc - start_cyc), 64'd3);
    check("e5_no_valid", 64'(vld_cnt - vb), 64'd0);
    check("e5_bx_out", 64'(bx_out), 64'd3);

    // E6: reset during RUN aborts the event; a following event runs normally.
    clear_counts();
    for (int ch = 0; ch < NCH; ch++) nent[ch][0] = 8'd10;
    start_event(3'd6);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("e6_rst_valid", 64'(out_valid), 64'd0);
    check("e6_rst_enb", 64'(in_enb), 64'd0);
    check("e6_rst_bx_out", 64'(bx_out), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    db = done_cnt; vb = vld_cnt;
    repeat (10) @(negedge clk);
    #1;
    check("e6_no_done", 64'(done_cnt - db), 64'd0);
    check("e6_no_stale", 64'(vld_cnt - vb), 64'd0);
    nent[0][1] = 8'd2; nent[3][1] = 8'd1;
    build_exp(1, 1000);
    gb = got.size(); db = done_cnt;
    start_event(3'd1);
    wait_done(db, 100, "e6b");
    cmp_words(gb, "e6b");
    check("e6b_bx_out", 64'(bx_out), 64'd1);
    check("e6b_trunc", 64'(truncated), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
